// File: rtl/wimax_pkg.sv
// Shared WiMAX PHY definitions: sample type, QPSK constellation levels,
// demodulator FSM states and the default weak-sample threshold.
package wimax_pkg;

    typedef logic signed [15:0] sample_t;

    localparam sample_t POINT_707  = 16'sd11585;
    localparam sample_t POINT_N707 = -16'sd11585;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_B1 = 2'd1,
        SEND_B2 = 2'd2
    } demod_state_t;

    localparam sample_t ERASE_THRESH_DEF = 16'sd2048;

endpackage

// File: rtl/qpsk_slicer.sv
// Combinational QPSK hard slicer: sign bits give {bit_1, bit_2}; with
// DEMOD_ERASURE_EN it also flags components whose magnitude is below threshold.
module qpsk_slicer #(
    parameter int                         SAMPLE_W     = 16,
    parameter logic signed [SAMPLE_W-1:0] ERASE_THRESH = 16'sd2048
) (
    input  logic signed [SAMPLE_W-1:0] i_in,
    input  logic signed [SAMPLE_W-1:0] q_in,
`ifdef DEMOD_ERASURE_EN
    output logic                       weak_i,
    output logic                       weak_q,
`endif
    output logic [1:0]                 bits
);

    // Zero is treated as positive, so a clear sign bit slices to 0.
    assign bits = {i_in[SAMPLE_W-1], q_in[SAMPLE_W-1]};

`ifdef DEMOD_ERASURE_EN
    logic [SAMPLE_W:0] i_ext_s;
    logic [SAMPLE_W:0] q_ext_s;
    logic [SAMPLE_W:0] i_abs_s;
    logic [SAMPLE_W:0] q_abs_s;
    logic [SAMPLE_W:0] thresh_s;

    // One extra bit keeps |-2^(SAMPLE_W-1)| representable.
    assign i_ext_s  = {i_in[SAMPLE_W-1], i_in};
    assign q_ext_s  = {q_in[SAMPLE_W-1], q_in};
    assign i_abs_s  = i_in[SAMPLE_W-1] ? ((~i_ext_s) + (SAMPLE_W+1)'(1)) : i_ext_s;
    assign q_abs_s  = q_in[SAMPLE_W-1] ? ((~q_ext_s) + (SAMPLE_W+1)'(1)) : q_ext_s;
    assign thresh_s = {1'b0, ERASE_THRESH};
    assign weak_i   = (i_abs_s < thresh_s);
    assign weak_q   = (q_abs_s < thresh_s);
`else
    logic unused_s;
    assign unused_s = ^{i_in[SAMPLE_W-2:0], q_in[SAMPLE_W-2:0], ERASE_THRESH};
`endif

endmodule

// File: rtl/qpsk_demodulator.sv
// QPSK hard-decision demodulator: accepts one I/Q symbol per handshake and
// streams bit_1 then bit_2 serially. Optional erasure flag via DEMOD_ERASURE_EN.
module qpsk_demodulator
    import wimax_pkg::*;
#(
    parameter int                         SAMPLE_W     = 16,
    parameter logic signed [SAMPLE_W-1:0] ERASE_THRESH = SAMPLE_W'(ERASE_THRESH_DEF),
    parameter int                         CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic signed [SAMPLE_W-1:0] i_in,
    input  logic signed [SAMPLE_W-1:0] q_in,
    output logic                       data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
`ifdef DEMOD_ERASURE_EN
    output logic                       erase_out,
`endif
    output logic [CNT_W-1:0]           sym_count
);

    demod_state_t     state_r;
    logic             valid_r;
    logic             data_r;
    logic             bit2_r;
    logic [CNT_W-1:0] count_r;
    logic [1:0]       bits_s;
    logic             ready_s;
    logic             accept_s;
`ifdef DEMOD_ERASURE_EN
    logic             weak_i_s;
    logic             weak_q_s;
    logic             weak_q_r;
    logic             erase_r;
`endif

    qpsk_slicer #(
        .SAMPLE_W     (SAMPLE_W),
        .ERASE_THRESH (ERASE_THRESH)
    ) u_slicer (
        .i_in   (i_in),
        .q_in   (q_in),
`ifdef DEMOD_ERASURE_EN
        .weak_i (weak_i_s),
        .weak_q (weak_q_s),
`endif
        .bits   (bits_s)
    );

    // A new symbol can enter while bit_2 is leaving, giving one bit per cycle.
    assign ready_s   = (state_r == IDLE) || ((state_r == SEND_B2) && ready_in);
    assign accept_s  = valid_in && ready_s;
    assign ready_out = ready_s;
    assign data_out  = data_r;
    assign valid_out = valid_r;
    assign sym_count = count_r;
`ifdef DEMOD_ERASURE_EN
    assign erase_out = erase_r;
`endif

    // Serialiser FSM, symbol latch and accepted-symbol counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            valid_r  <= 1'b0;
            data_r   <= 1'b0;
            bit2_r   <= 1'b0;
            count_r  <= '0;
`ifdef DEMOD_ERASURE_EN
            weak_q_r <= 1'b0;
            erase_r  <= 1'b0;
`endif
        end else if (accept_s) begin
            state_r  <= SEND_B1;
            valid_r  <= 1'b1;
            data_r   <= bits_s[1];
            bit2_r   <= bits_s[0];
            count_r  <= count_r + CNT_W'(1);
`ifdef DEMOD_ERASURE_EN
            weak_q_r <= weak_q_s;
            erase_r  <= weak_i_s;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                SEND_B1: begin
                    if (ready_in) begin
                        state_r <= SEND_B2;
                        data_r  <= bit2_r;
`ifdef DEMOD_ERASURE_EN
                        erase_r <= weak_q_r;
`endif
                    end else begin
                        state_r <= SEND_B1;
                    end
                end
                SEND_B2: begin
                    if (ready_in) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                        data_r  <= 1'b0;
`ifdef DEMOD_ERASURE_EN
                        erase_r <= 1'b0;
`endif
                    end else begin
                        state_r <= SEND_B2;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    data_r  <= 1'b0;
`ifdef DEMOD_ERASURE_EN
                    erase_r <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: doc/qpsk_demodulator.md
Name: qpsk_demodulator

Overview:
- Receive-side counterpart of the QPSK modulator.
- Accepts one I/Q symbol per handshake and hard-slices it into two bits.
- Serialises the bits one per handshake onto a single-bit stream, bit_1 (from I) first, then bit_2 (from Q).
- Sits between the channel/equaliser sample path and the downstream bit de-interleaver/decoder.

Parameters:
- SAMPLE_W, 16, width of the signed I/Q samples.
- ERASE_THRESH, 16'sd2048, magnitude below which a component is flagged weak (used only with the optional feature).
- CNT_W, 16, width of the accepted-symbol counter.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset; asynchronous and active-high.
- valid_in  input  1  I/Q symbol valid.
- ready_out  output  1  block can accept a symbol.
- i_in  input  SAMPLE_W  signed in-phase sample.
- q_in  input  SAMPLE_W  signed quadrature sample.
- data_out  output  1  serial demodulated bit.
- valid_out  output  1  data_out valid.
- ready_in  input  1  downstream accepts data_out.
- sym_count  output  CNT_W  number of symbols accepted, wrapping.
- erase_out  output  1  current bit is low-confidence (present only with DEMOD_ERASURE_EN).

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - state=IDLE, valid_out=0, data_out=0, sym_count=0, erase_out=0.
  - ready_out=1 immediately after deassertion.
- Slicing:
  - bit_1 = i_in[SAMPLE_W-1] (sign of I); bit_2 = q_in[SAMPLE_W-1] (sign of Q).
  - Zero counts as positive, giving bit 0.
  - Mapping: (+,+)->00, (+,-)->01, (-,+)->10, (-,-)->11, i.e. the exact inverse of the modulator's constellation.
- Both bits are registered on the symbol handshake.
- FSM states:
  - IDLE: valid_out=0. On valid_in&&ready_out, latch both bits and go to SEND_B1.
  - SEND_B1: valid_out=1, data_out=bit_1. On ready_in, go to SEND_B2.
  - SEND_B2: valid_out=1, data_out=bit_2. On ready_in:
    - if valid_in, latch the new symbol and go to SEND_B1;
    - otherwise go to IDLE.
- ready_out is combinational: (state==IDLE) || (state==SEND_B2 && ready_in). This allows back-to-back symbols at 1 bit/cycle.
- Latency: a symbol accepted at edge N gives valid_out=1, data_out=bit_1 in the cycle after edge N. bit_2 is presented in the cycle after bit_1 is accepted.
- Output hold rules:
  - While valid_out=1 and ready_in=0, data_out, valid_out and erase_out hold stable and state does not change.
  - valid_out never drops without a handshake.
- sym_count increments by 1 on every accepted symbol and wraps from 2^CNT_W-1 to 0 with no flag.
- valid_in while ready_out=0: the symbol is not consumed, and the upstream must hold it.
- Reset asserted mid-serialisation: the pending bits are discarded and the block returns to IDLE; no partial bit is emitted after reset.
- The most negative input (-32768) slices as negative. No arithmetic overflow is possible, because slicing uses sign bits only.

Optional Feature:
- Macro: DEMOD_ERASURE_EN.
- With the macro defined:
  - On symbol accept, register weak_i = (|i_in| < ERASE_THRESH) and weak_q = (|q_in| < ERASE_THRESH).
  - Compute absolute values in SAMPLE_W+1 bits so that -32768 is handled correctly.
  - erase_out = weak_i during SEND_B1 and weak_q during SEND_B2; 0 in IDLE and after reset.
  - erase_out follows the same hold rules as data_out.
- Without the macro: the erase_out port and the weak registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package wimax_pkg holds:
  - sample typedef (logic signed [15:0]);
  - constellation constants POINT_707 = 16'sd11585 and POINT_N707 = -16'sd11585;
  - demodulator FSM state enum (IDLE, SEND_B1, SEND_B2);
  - ERASE_THRESH default.
- One sub-module, qpsk_slicer: combinational sign/magnitude slice producing {bit_1, bit_2} and the weak flags.
- FSM, registers and counter live in qpsk_demodulator.

Test Plan:
- Reset → ready_out=1, valid_out=0, sym_count=0. Assert rst mid-SEND_B1 → valid_out=0 immediately; IDLE after release.
- Symbols (11585,11585), (11585,-11585), (-11585,11585), (-11585,-11585) with ready_in=1 → bit stream 00 01 10 11 and sym_count=4.
- Back-to-back valid_in=1 with ready_in=1 held → one bit per cycle with no bubble; ready_out pulses high only in SEND_B2 cycles.
- ready_in=0 for 5 cycles during SEND_B2 → data_out and valid_out held stable; ready_out=0; the upstream symbol is not consumed until the handshake.
- Edge samples (0,-32768) → bits 0,1; 65536 accepted symbols → sym_count wraps to 0.
- With DEMOD_ERASURE_EN: symbol (1000,-11585) → erase_out=1 on bit_1, 0 on bit_2. Symbol (-32768,2047) → erase_out 0 then 1.
